// File: rtl/led_pwm_pkg.sv
// Shared types, constants and duty clamp helpers for the LED fade sequencer.
package led_pwm_pkg;

    localparam int DUTY_W = 8;
    localparam int CHAN_N = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_HOLD_HIGH,
        ST_RAMP_DOWN,
        ST_HOLD_LOW
    } fade_state_e;

    // The sum is formed one bit wider so a near-255 duty cannot wrap before the clamp.
    function automatic logic [DUTY_W-1:0] clamp_up(input logic [DUTY_W-1:0] d,
                                                   input logic [DUTY_W-1:0] step,
                                                   input logic [DUTY_W-1:0] lim);
        logic [DUTY_W:0] sum;
        sum = {1'b0, d} + {1'b0, step};
        return (sum >= {1'b0, lim}) ? lim : sum[DUTY_W-1:0];
    endfunction

    function automatic logic [DUTY_W-1:0] clamp_down(input logic [DUTY_W-1:0] d,
                                                     input logic [DUTY_W-1:0] step);
        return (d > step) ? (d - step) : '0;
    endfunction

endpackage

// File: rtl/led_fade_if.sv
// Control/status bundle between the fade sequencer and its host.
interface led_fade_if;
    import led_pwm_pkg::*;

    logic              en;
    logic [CHAN_N-1:0] led;
    logic [DUTY_W-1:0] duty;
    logic [1:0]        chan;
    logic              busy;

    modport master (output en, input led, duty, chan, busy);
    modport slave  (input en, output led, duty, chan, busy);
endinterface

// File: rtl/pwm_core.sv
// PWM period counter with registered per-channel compare; only the active channel can light.
module pwm_core
    import led_pwm_pkg::*;
#(
    parameter int PWM_PERIOD = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        chan,
    input  logic [DUTY_W-1:0] duty,
    output logic [CHAN_N-1:0] led
);

    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic [CHAN_N-1:0] led_q, led_d;

    always_comb begin
        cnt_d = '0;
        if (en && (cnt_q != DUTY_W'(PWM_PERIOD - 1)))
            cnt_d = cnt_q + DUTY_W'(1);
        // Gating on en makes the LEDs go dark in the same cycle the FSM drops to idle.
        led_d = '0;
        for (int i = 0; i < CHAN_N; i++)
            led_d[i] = en && (chan == 2'(i)) && (cnt_q < duty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            led_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_fade_sequencer.sv
// Breathing-pattern sequencer: step prescaler, hold counter and duty FSM, round-robin over three LEDs.
//   state        | meaning
//   ST_IDLE      | pattern stopped, duty 0, channel 0
//   ST_RAMP_UP   | duty rises by STEP per tick, clamped at PWM_PERIOD
//   ST_HOLD_HIGH | full brightness for HOLD_STEPS ticks
//   ST_RAMP_DOWN | duty falls by STEP per tick, clamped at 0
//   ST_HOLD_LOW  | dark for HOLD_STEPS ticks, then next channel
module led_fade_sequencer
    import led_pwm_pkg::*;
#(
    parameter int CLK_DIV    = 1_000_000,
    parameter int PWM_PERIOD = 100,
    parameter int STEP       = 4,
    parameter int HOLD_STEPS = 25
) (
    input logic         clk,
    input logic         rst,
    led_fade_if.slave   bus
);

    localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_STEPS + 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PWM_PERIOD);
    localparam logic [DUTY_W-1:0] DUTY_STEP = DUTY_W'(STEP);

    fade_state_e       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [1:0]        chan_q, chan_d;
    logic              busy_q, busy_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    logic              tick;

    assign tick     = bus.en && (pre_q == PRE_W'(CLK_DIV - 1));
    assign hold_inc = hold_q + HOLD_W'(1);

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        chan_d  = chan_q;
        hold_d  = hold_q;
        pre_d   = (bus.en && !tick) ? pre_q + PRE_W'(1) : '0;

        if (!bus.en) begin
            state_d = ST_IDLE;
            duty_d  = '0;
            chan_d  = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    duty_d  = '0;
                    hold_d  = '0;
                    state_d = ST_RAMP_UP;
                end
                ST_RAMP_UP: if (tick) begin
                    duty_d = clamp_up(duty_q, DUTY_STEP, DUTY_MAX);
                    if (duty_d == DUTY_MAX) begin
                        state_d = ST_HOLD_HIGH;
                        hold_d  = '0;
                    end
                end
                ST_HOLD_HIGH: if (tick) begin
                    hold_d = hold_inc;
                    if (hold_inc == HOLD_W'(HOLD_STEPS)) begin
                        state_d = ST_RAMP_DOWN;
                        hold_d  = '0;
                    end
                end
                ST_RAMP_DOWN: if (tick) begin
                    duty_d = clamp_down(duty_q, DUTY_STEP);
                    if (duty_d == '0) begin
                        state_d = ST_HOLD_LOW;
                        hold_d  = '0;
                    end
                end
                ST_HOLD_LOW: if (tick) begin
                    hold_d = hold_inc;
                    if (hold_inc == HOLD_W'(HOLD_STEPS)) begin
                        state_d = ST_RAMP_UP;
                        hold_d  = '0;
                        chan_d  = (chan_q == 2'd2) ? 2'd0 : chan_q + 2'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            chan_q  <= '0;
            busy_q  <= 1'b0;
            pre_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            chan_q  <= chan_d;
            busy_q  <= busy_d;
            pre_q   <= pre_d;
            hold_q  <= hold_d;
        end
    end

    pwm_core #(.PWM_PERIOD(PWM_PERIOD)) u_pwm_core (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .chan (chan_q),
        .duty (duty_q),
        .led  (bus.led)
    );

    assign bus.duty = duty_q;
    assign bus.chan = chan_q;
    assign bus.busy = busy_q;

endmodule
